// File: rtl/sine_wave_sequencer.sv
// sine_wave_sequencer: per-frame phase sequencer feeding an external sine LUT.
// Once per accepted frame_tick it advances an 8-bit phase accumulator. It then
// reads two adjacent LUT samples and linearly interpolates between them using
// the 4-bit phase fraction.
//
// Ports:
//   clk        in  1 : system clock, all state on rising edge
//   rst        in  1 : synchronous active-high reset
//   frame_tick in  1 : one-cycle frame-start pulse
//   speed      in  4 : phase increment per frame (1/16 LUT-step units)
//   freeze     in  1 : hold phase on an accepted tick, still refresh the wave
//   lut_pos    out 4 : LUT index (registered)
//   lut_data   in  8 : LUT sample, combinational function of lut_pos
//   phase      out 8 : accumulator, [7:4] index, [3:0] fraction
//   wave_y     out 8 : interpolated sample, held between updates
//   wave_valid out 1 : one-cycle pulse when wave_y updates
//   busy       out 1 : high whenever the sequencer is not idle
//   overrun    out 1 : sticky, a tick arrived while busy
module sine_wave_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [3:0] speed,
  input  logic       freeze,
  output logic [3:0] lut_pos,
  input  logic [7:0] lut_data,
  output logic [7:0] phase,
  output logic [7:0] wave_y,
  output logic       wave_valid,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned FRAC_W  = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PHASE_W = IDX_W + FRAC_W;
  localparam int unsigned DIFF_W  = DATA_W + 1;
  localparam int unsigned PROD_W  = DIFF_W + FRAC_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_A = 2'd1,
    S_LOAD_B = 2'd2,
    S_BLEND  = 2'd3
  } state_t;

  state_t              r_state;
  logic [PHASE_W-1:0]  r_phase;
  logic [IDX_W-1:0]    r_lut_pos;
  logic [FRAC_W-1:0]   r_frac;
  logic [DATA_W-1:0]   r_sample_a;
  logic [DATA_W-1:0]   r_sample_b;
  logic [DATA_W-1:0]   r_wave_y;
  logic                r_wave_valid;
  logic                r_busy;
  logic                r_overrun;

  state_t              w_state_next;
  logic [PHASE_W-1:0]  w_phase_next;
  logic [PHASE_W-1:0]  w_phase_tick;
  logic [IDX_W-1:0]    w_lut_pos_next;
  logic [FRAC_W-1:0]   w_frac_next;
  logic [DATA_W-1:0]   w_sample_a_next;
  logic [DATA_W-1:0]   w_sample_b_next;
  logic [DATA_W-1:0]   w_wave_y_next;
  logic                w_wave_valid_next;
  logic                w_overrun_next;

  logic signed [DIFF_W-1:0] w_diff;
  logic signed [PROD_W-1:0] w_prod;
  logic [DATA_W-1:0]        w_blend;

  // Phase that an accepted tick would produce (wraps mod 256)
  assign w_phase_tick = freeze ? r_phase : r_phase + PHASE_W'(speed);

  // Linear blend: a + floor((b - a) * frac / 16); result stays within [a, b]
  assign w_diff  = $signed({1'b0, r_sample_b}) - $signed({1'b0, r_sample_a});
  assign w_prod  = PROD_W'(w_diff) * PROD_W'($signed({1'b0, r_frac}));
  assign w_blend = r_sample_a + DATA_W'(w_prod >>> FRAC_W);

  // Next-state and datapath update
  always_comb begin
    w_state_next      = r_state;
    w_phase_next      = r_phase;
    w_lut_pos_next    = r_lut_pos;
    w_frac_next       = r_frac;
    w_sample_a_next   = r_sample_a;
    w_sample_b_next   = r_sample_b;
    w_wave_y_next     = r_wave_y;
    w_wave_valid_next = 1'b0;
    w_overrun_next    = r_overrun;

    case (r_state)
      S_IDLE: begin
        if (frame_tick) begin
          w_phase_next   = w_phase_tick;
          w_lut_pos_next = w_phase_tick[PHASE_W-1:FRAC_W];
          w_frac_next    = w_phase_tick[FRAC_W-1:0];
          w_state_next   = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        w_sample_a_next = lut_data;
        w_lut_pos_next  = r_lut_pos + IDX_W'(1);
        w_state_next    = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_sample_b_next = lut_data;
        w_state_next    = S_BLEND;
      end
      S_BLEND: begin
        w_wave_y_next     = w_blend;
        w_wave_valid_next = 1'b1;
        w_state_next      = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // Ticks arriving outside IDLE are dropped and flagged
    if (frame_tick && (r_state != S_IDLE)) begin
      w_overrun_next = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_lut_pos    <= '0;
      r_frac       <= '0;
      r_sample_a   <= '0;
      r_sample_b   <= '0;
      r_wave_y     <= '0;
      r_wave_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_phase      <= w_phase_next;
      r_lut_pos    <= w_lut_pos_next;
      r_frac       <= w_frac_next;
      r_sample_a   <= w_sample_a_next;
      r_sample_b   <= w_sample_b_next;
      r_wave_y     <= w_wave_y_next;
      r_wave_valid <= w_wave_valid_next;
      r_busy       <= (w_state_next != S_IDLE);
      r_overrun    <= w_overrun_next;
    end
  end

  assign lut_pos    = r_lut_pos;
  assign phase      = r_phase;
  assign wave_y     = r_wave_y;
  assign wave_valid = r_wave_valid;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sine_wave_sequencer.sv
// Self-checking bench for sine_wave_sequencer with a programmable 16-entry LUT
// model. Expected wave samples are queued when a tick is driven and compared
// when wave_valid fires.
module tb_sine_wave_sequencer;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic [3:0] speed;
  logic       freeze;
  logic [3:0] lut_pos;
  logic [7:0] lut_data;
  logic [7:0] phase;
  logic [7:0] wave_y;
  logic       wave_valid;
  logic       busy;
  logic       overrun;

  logic [7:0] lut_table [16];
  logic [7:0] m_phase;
  logic [7:0] last_exp;
  int         n_checks;
  int         n_fail;
  int         n_valid;
  int         cyc;
  int         exp_q[$];
  int         lat_q[$];

  sine_wave_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .speed      (speed),
    .freeze     (freeze),
    .lut_pos    (lut_pos),
    .lut_data   (lut_data),
    .phase      (phase),
    .wave_y     (wave_y),
    .wave_valid (wave_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  assign lut_data = lut_table[lut_pos];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference interpolation: a + floor((b - a) * f / 16)
  function automatic logic [7:0] interp(input int a, input int b, input int f);
    int d;
    int q;
    d = (b - a) * f;
    if (d >= 0) q = d / 16;
    else        q = -((-d + 15) / 16);
    return 8'(a + q);
  endfunction

  // Scoreboard consumer: every wave_valid must match the oldest expectation
  always @(posedge clk) begin
    #2;
    if (wave_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 1, 0);
      end else begin
        check_eq("wave_y", int'(wave_y), exp_q.pop_front());
        check_eq("latency", cyc, lat_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_phase", int'(phase), 0);
    check_eq("rst_lut_pos", int'(lut_pos), 0);
    check_eq("rst_wave_y", int'(wave_y), 0);
    check_eq("rst_valid", int'(wave_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    m_phase = 8'h00;
    exp_q.delete();
    lat_q.delete();
  endtask

  // One accepted tick followed by the full update window
  task automatic do_update(input logic [3:0] spd, input logic frz);
    logic [3:0] idx;
    logic [3:0] idx_b;
    @(negedge clk);
    frame_tick = 1'b1;
    speed = spd;
    freeze = frz;
    if (!frz) m_phase = m_phase + 8'(spd);
    idx = m_phase[7:4];
    idx_b = idx + 4'd1;
    last_exp = interp(int'(lut_table[idx]), int'(lut_table[idx_b]), int'(m_phase[3:0]));
    exp_q.push_back(int'(last_exp));
    lat_q.push_back(cyc + 4);
    @(negedge clk);
    frame_tick = 1'b0;
    freeze = 1'b0;
    check_eq("phase", int'(phase), int'(m_phase));
    check_eq("lut_pos_a", int'(lut_pos), int'(idx));
    check_eq("busy", int'(busy), 1);
    @(negedge clk);
    check_eq("lut_pos_b", int'(lut_pos), int'(idx_b));
    @(negedge clk);
    @(negedge clk);
    check_eq("busy_done", int'(busy), 0);
    check_eq("pending", exp_q.size(), 0);
    check_eq("wave_hold", int'(wave_y), int'(last_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    n_checks = 0;
    n_fail = 0;
    n_valid = 0;
    cyc = 0;
    rst = 1'b1;
    frame_tick = 1'b0;
    speed = 4'd0;
    freeze = 1'b0;
    m_phase = 8'h00;
    for (int i = 0; i < 16; i++) lut_table[i] = 8'($urandom_range(0, 255));

    // Reset and idle quiet period
    do_reset();
    v0 = n_valid;
    repeat (10) @(negedge clk);
    check_eq("idle_no_valid", n_valid - v0, 0);

    // Basic interpolation
    lut_table[0] = 8'd10;
    lut_table[1] = 8'd26;
    do_update(4'd4, 1'b0);
    check_eq("basic_phase", int'(phase), 8'h04);
    check_eq("basic_y", int'(wave_y), 14);

    // Descending blend, exact midpoint
    do_reset();
    lut_table[3] = 8'd200;
    lut_table[4] = 8'd100;
    do_update(4'd15, 1'b0);
    do_update(4'd15, 1'b0);
    do_update(4'd15, 1'b0);
    do_update(4'd11, 1'b0);
    check_eq("desc_phase", int'(phase), 8'h38);
    check_eq("desc_y", int'(wave_y), 150);

    // Floor toward -inf on a tiny negative step
    do_reset();
    lut_table[4] = 8'd199;
    do_update(4'd15, 1'b0);
    do_update(4'd15, 1'b0);
    do_update(4'd15, 1'b0);
    do_update(4'd4, 1'b0);
    check_eq("floor_phase", int'(phase), 8'h31);
    check_eq("floor_y", int'(wave_y), 199);

    // Index and phase wrap
    do_reset();
    for (int i = 0; i < 16; i++) do_update(4'd15, 1'b0);
    check_eq("wrap_phase_f0", int'(phase), 8'hF0);
    do_update(4'd15, 1'b0);
    check_eq("wrap_phase_ff", int'(phase), 8'hFF);
    do_update(4'd15, 1'b0);
    check_eq("wrap_phase_0e", int'(phase), 8'h0E);

    // Overrun: ticks in LOAD_A and BLEND are both dropped
    do_reset();
    v0 = n_valid;
    @(negedge clk);
    frame_tick = 1'b1;
    speed = 4'd3;
    m_phase = m_phase + 8'd3;
    last_exp = interp(int'(lut_table[0]), int'(lut_table[1]), 3);
    exp_q.push_back(int'(last_exp));
    lat_q.push_back(cyc + 4);
    @(negedge clk);
    check_eq("ovr_pre", int'(overrun), 0);
    @(negedge clk);
    frame_tick = 1'b0;
    check_eq("ovr_set", int'(overrun), 1);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("ovr_one_valid", n_valid - v0, 1);
    check_eq("ovr_phase", int'(phase), int'(m_phase));
    check_eq("ovr_busy", int'(busy), 0);
    check_eq("ovr_sticky", int'(overrun), 1);

    // Freeze: phase holds but wave refreshes from an updated table
    lut_table[0] = 8'd40;
    lut_table[1] = 8'd8;
    v0 = n_valid;
    do_update(4'd9, 1'b1);
    check_eq("frz_phase", int'(phase), 8'h03);
    check_eq("frz_valid", n_valid - v0, 1);
    check_eq("frz_y", int'(wave_y), 34);

    // Reset while in LOAD_B aborts without a pulse
    do_reset();
    lut_table[0] = 8'd10;
    lut_table[1] = 8'd26;
    v0 = n_valid;
    @(negedge clk);
    frame_tick = 1'b1;
    speed = 4'd4;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_phase", int'(phase), 0);
    check_eq("mid_lut_pos", int'(lut_pos), 0);
    check_eq("mid_wave_y", int'(wave_y), 0);
    check_eq("mid_busy", int'(busy), 0);
    check_eq("mid_overrun", int'(overrun), 0);
    repeat (4) @(negedge clk);
    check_eq("mid_no_valid", n_valid - v0, 0);
    m_phase = 8'h00;
    do_update(4'd4, 1'b0);
    check_eq("mid_after_y", int'(wave_y), 14);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
